// File: rtl/lzd_seq_scan.sv
// lzd_seq_scan: sequential leading-zero counter for the fp32 max/min datapath.
// Scans one nibble per cycle, MSB first, through a single shared lzd_4b and
// stops at the first non-zero nibble. Valid/ready handshakes on both sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; o_ready high
// SCAN  | examining nibble nib_idx of the captured word
// DONE  | result held on o_lzc/o_zero with o_valid until taken

// 4-bit priority encoder: po is the index of the highest set bit.
module lzd_4b (
  input  logic [3:0] nib,
  output logic [1:0] po,
  output logic       po_valid
);

  // Highest set bit wins; po is don't-care when the nibble is zero.
  always_comb begin
    po_valid = |nib;
    if (nib[3])      po = 2'd3;
    else if (nib[2]) po = 2'd2;
    else if (nib[1]) po = 2'd1;
    else             po = 2'd0;
  end

endmodule

module lzd_seq_scan #(
  parameter  int WIDTH = 32,
  localparam int LZC_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LZC_W-1:0] o_lzc,
  output logic             o_zero
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_reg;
  logic [IDX_W-1:0] nib_idx;
  logic [3:0]       nibble;
  logic [1:0]       po;
  logic             po_valid;

  // Nibble mux: index 0 is the most significant nibble of the data register.
  always_comb begin
    nibble = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (nib_idx == IDX_W'(i)) nibble = data_reg[WIDTH-1-4*i -: 4];
    end
  end

  lzd_4b u_lzd (
    .nib      (nibble),
    .po       (po),
    .po_valid (po_valid)
  );

  // Reset gates o_ready directly so no word is taken in a reset cycle.
  assign o_ready = (state == IDLE) & ~i_rst;

  // Scan FSM with registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      data_reg <= '0;
      nib_idx  <= '0;
      o_valid  <= 1'b0;
      o_lzc    <= '0;
      o_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            data_reg <= i_data;
            nib_idx  <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (po_valid) begin
            // nib_idx*4 + (3-po) without an adder, exact since WIDTH%4 == 0.
            o_lzc   <= LZC_W'({nib_idx, ~po});
            o_zero  <= 1'b0;
            o_valid <= 1'b1;
            state   <= DONE;
          end else if (nib_idx == IDX_W'(NIB - 1)) begin
            o_lzc   <= LZC_W'(WIDTH);
            o_zero  <= 1'b1;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzd_seq_scan.sv
// Scoreboard bench for lzd_seq_scan (WIDTH=32). The driver pushes the
// hand-computed count, zero flag and expected o_valid cycle on acceptance;
// the monitor compares whenever o_valid is high.
module tb_lzd_seq_scan;

  localparam int WIDTH = 32;
  localparam int LZC_W = $clog2(WIDTH + 1);

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [LZC_W-1:0] o_lzc;
  logic             o_zero;

  lzd_seq_scan #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_lzc   (o_lzc),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  typedef struct {
    int lzc;
    int zero;
    int vcyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; holds i_valid until accepted, returns acceptance cycle.
  task automatic send(input logic [WIDTH-1:0] d, input int lzc, input int zero,
                      input int lat, output int acc);
    exp_t e;
    acc = -1;
    i_valid = 1'b1;
    i_data  = d;
    for (int n = 0; n < 50; n++) begin
      if (o_ready) begin
        acc    = cyc;
        e.lzc  = lzc;
        e.zero = zero;
        e.vcyc = cyc + lat;
        q.push_back(e);
        @(negedge i_clk);
        return;
      end
      @(negedge i_clk);
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (q.size() == 0) break;
      @(negedge i_clk);
    end
    chk("drain_queue_empty", q.size(), 0);
    @(negedge i_clk);
  endtask

  // Monitor: latency on o_valid rise, values every valid cycle, pop on handoff.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge i_clk);
      #1;
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q[0];
          if (!prev) chk("latency", cyc, e.vcyc);
          chk("lzc", int'(o_lzc), e.lzc);
          chk("zero", int'(o_zero), e.zero);
          if (i_ready) void'(q.pop_front());
        end
      end
      prev = o_valid;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] d;
    int lzc;
    int zero;
    int lat;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int acc0, acc1, acc2;

    vecs[0] = '{32'h8000_0000,  0, 0, 2};
    vecs[1] = '{32'h0001_2345, 15, 0, 5};
    vecs[2] = '{32'h0400_0000,  5, 0, 3};
    vecs[3] = '{32'h0000_0001, 31, 0, 9};
    vecs[4] = '{32'h0000_0000, 32, 1, 9};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;

    repeat (3) @(negedge i_clk);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_lzc", int'(o_lzc), 0);
    chk("rst_zero", int'(o_zero), 0);
    i_rst = 1'b0;
    #1;
    chk("ready_after_reset", int'(o_ready), 1);
    @(negedge i_clk);

    // Directed single words with immediate acceptance downstream.
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].lzc, vecs[i].zero, vecs[i].lat, acc0);
      i_valid = 1'b0;
      drain();
    end

    // Backpressure: result held, new words ignored, o_ready low.
    i_ready = 1'b0;
    send(32'h00F0_0000, 8, 0, 4, acc0);
    i_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (o_valid) break;
      @(negedge i_clk);
    end
    for (int n = 0; n < 5; n++) begin
      i_valid = 1'b1;
      i_data  = 32'hFFFF_FFFF;
      chk("bp_ready_low", int'(o_ready), 0);
      chk("bp_valid_held", int'(o_valid), 1);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("ready_after_handoff", int'(o_ready), 1);
    chk("valid_after_handoff", int'(o_valid), 0);
    drain();

    // Back-to-back with i_valid held high: II = latency + 1.
    send(32'h8000_0000,  0, 0, 2, acc0);
    send(32'h0000_0010, 27, 0, 8, acc1);
    send(32'hFFFF_FFFF,  0, 0, 2, acc2);
    i_valid = 1'b0;
    chk("b2b_spacing_1", acc1 - acc0, 3);
    chk("b2b_spacing_2", acc2 - acc1, 9);
    drain();

    // Reset mid-scan abandons the word.
    send(32'h0000_0001, 31, 0, 9, acc0);
    i_valid = 1'b0;
    while (cyc < acc0 + 4) @(negedge i_clk);
    i_rst = 1'b1;
    q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_ready", int'(o_ready), 1);
    chk("rst_mid_valid", int'(o_valid), 0);
    chk("rst_mid_lzc", int'(o_lzc), 0);
    repeat (8) @(negedge i_clk);
    send(32'h1000_0000, 3, 0, 2, acc0);
    i_valid = 1'b0;
    drain();

    repeat (3) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
